// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - CPU-side BR/BG arbiter and command issuer for the DMA write engine
module dma_bus_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int BR_TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 dev_req,
  input  logic [WORD_SIZE-1:0] dev_addr,
  input  logic                 cpu_mem_busy,
  input  logic                 BR,
  input  logic                 interrupt,
  output logic                 BG,
  output logic [WORD_SIZE-1:0] cmd,
  output logic                 cpu_bus_stall,
  output logic                 dma_done,
  output logic                 dma_error,
  output logic                 req_dropped
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_BR,
    QUIESCE,
    GRANT,
    RELEASE,
    WAIT_IRQ
  } state_t;

  localparam logic [WORD_SIZE-1:0] TMO_LAST = WORD_SIZE'(BR_TIMEOUT - 1);

  state_t               state;
  state_t               next_state;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] tmo_cnt;
  logic                 irq_seen;
  logic                 irq_next;
  logic                 done_next;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_cnt >= TMO_LAST);

  // The command bus is shared with the DMA, so it is only driven during CMD.
  assign cmd = (state == CMD) ? addr_q : {WORD_SIZE{1'bz}};

  // State register plus the registered bus-control outputs, decoded from the next state.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state         <= IDLE;
      irq_seen      <= 1'b0;
      BG            <= 1'b0;
      cpu_bus_stall <= 1'b0;
      dma_done      <= 1'b0;
    end else begin
      state         <= next_state;
      irq_seen      <= irq_next;
      BG            <= (next_state == GRANT);
      cpu_bus_stall <= (next_state == QUIESCE) || (next_state == GRANT) ||
                       (next_state == RELEASE);
      dma_done      <= done_next;
    end
  end

  // Next-state logic; an end-of-transfer pulse that lands with or just after BR
  // falling is remembered so dma_done fires on entry to WAIT_IRQ.
  always_comb begin
    next_state = state;
    irq_next   = irq_seen;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        irq_next = 1'b0;
        if (dev_req) next_state = CMD;
      end
      CMD: next_state = WAIT_BR;
      WAIT_BR: begin
        if (BR) next_state = cpu_mem_busy ? QUIESCE : GRANT;
        else if (tmo_hit) next_state = IDLE;
      end
      QUIESCE: begin
        if (!BR) next_state = IDLE;
        else if (!cpu_mem_busy) next_state = GRANT;
      end
      GRANT: begin
        if (!BR) begin
          next_state = RELEASE;
          irq_next   = interrupt;
        end
      end
      RELEASE: begin
        next_state = WAIT_IRQ;
        if (interrupt || irq_seen) begin
          irq_next  = 1'b1;
          done_next = 1'b1;
        end
      end
      WAIT_IRQ: begin
        if (irq_seen) begin
          next_state = IDLE;
          irq_next   = 1'b0;
        end else if (interrupt) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address latch, saturating BR timeout counter and the sticky status flags.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      addr_q      <= '0;
      tmo_cnt     <= '0;
      dma_error   <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      if (state == IDLE && dev_req) addr_q <= dev_addr;
      if (state != IDLE && dev_req) req_dropped <= 1'b1;
      if (state == WAIT_BR && !BR && tmo_hit) dma_error <= 1'b1;
      if (state == CMD) tmo_cnt <= '0;
      else if (state == WAIT_BR && tmo_cnt != '1) tmo_cnt <= tmo_cnt + WORD_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed scoreboard bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        dev_req;
  logic [15:0] dev_addr;
  logic        cpu_mem_busy;
  logic        BR;
  logic        interrupt;
  logic        BG;
  logic [15:0] cmd;
  logic        cpu_bus_stall;
  logic        dma_done;
  logic        dma_error;
  logic        req_dropped;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cmd_q[$];
  int          done_q[$];
  logic [15:0] zz = 16'hzzzz;

  dma_bus_arbiter #(.WORD_SIZE(16), .BR_TIMEOUT(64)) dut (
    .CLK(CLK), .reset_n(reset_n), .dev_req(dev_req), .dev_addr(dev_addr),
    .cpu_mem_busy(cpu_mem_busy), .BR(BR), .interrupt(interrupt), .BG(BG),
    .cmd(cmd), .cpu_bus_stall(cpu_bus_stall), .dma_done(dma_done),
    .dma_error(dma_error), .req_dropped(req_dropped)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; samples at the falling edge and retires scoreboard entries.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    if (cmd !== zz) begin
      if (cmd_q.size() == 0) chk("unexpected_cmd", {16'h0, cmd}, {16'h0, zz});
      else chk("cmd", {16'h0, cmd}, {16'h0, cmd_q.pop_front()});
    end
    if (dma_done === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", {31'h0, dma_done}, 32'h0);
      else begin
        void'(done_q.pop_front());
        chk("done_bus_free", {30'h0, BG, cpu_bus_stall}, 32'h0);
      end
    end
  endtask

  task automatic start(input logic [15:0] a);
    dev_req  = 1'b1;
    dev_addr = a;
    cmd_q.push_back(a);
    tick();
    dev_req  = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    BR = 1'b0;
    tick();
    chk({tag, "_release_bg"}, {31'h0, BG}, 32'h0);
    chk({tag, "_release_stall"}, {31'h0, cpu_bus_stall}, 32'h1);
    interrupt = 1'b1;
    done_q.push_back(1);
    tick();
    interrupt = 1'b0;
    tick();
    chk({tag, "_idle_stall"}, {31'h0, cpu_bus_stall}, 32'h0);
    chk({tag, "_done_drained"}, done_q.size(), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; dev_req = 1'b0; dev_addr = '0; cpu_mem_busy = 1'b0;
    BR = 1'b0; interrupt = 1'b0;
    tick(); tick();
    chk("rst_bg", {31'h0, BG}, 32'h0);
    chk("rst_cmd", {16'h0, cmd}, {16'h0, zz});
    chk("rst_stall", {31'h0, cpu_bus_stall}, 32'h0);
    chk("rst_done", {31'h0, dma_done}, 32'h0);
    chk("rst_err", {31'h0, dma_error}, 32'h0);
    chk("rst_drop", {31'h0, req_dropped}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Nominal transfer
    start(16'h01F4);
    tick();
    tick();
    BR = 1'b1;
    chk("nom_bg_before", {31'h0, BG}, 32'h0);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("nom_bg_held", {31'h0, BG}, 32'h1);
      chk("nom_stall_held", {31'h0, cpu_bus_stall}, 32'h1);
    end
    BR = 1'b0;
    tick();
    chk("nom_bg_fall", {31'h0, BG}, 32'h0);
    interrupt = 1'b1;
    done_q.push_back(1);
    tick();
    interrupt = 1'b0;
    tick();
    chk("nom_done_drained", done_q.size(), 32'h0);
    chk("nom_drop", {31'h0, req_dropped}, 32'h0);

    // Busy CPU: quiesce until cpu_mem_busy falls
    start(16'h0300);
    tick();
    BR = 1'b1; cpu_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_stall", {31'h0, cpu_bus_stall}, 32'h1);
      chk("busy_bg_low", {31'h0, BG}, 32'h0);
    end
    cpu_mem_busy = 1'b0;
    tick();
    chk("busy_bg_rise", {31'h0, BG}, 32'h1);
    finish_xfer("busy");

    // BR timeout
    start(16'h0400);
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("tmo_err_low", {31'h0, dma_error}, 32'h0);
      chk("tmo_bg_low", {31'h0, BG}, 32'h0);
    end
    tick();
    chk("tmo_err_set", {31'h0, dma_error}, 32'h1);
    chk("tmo_bg", {31'h0, BG}, 32'h0);
    start(16'h0410);
    tick();
    BR = 1'b1;
    tick();
    chk("tmo_next_bg", {31'h0, BG}, 32'h1);
    finish_xfer("tmo_next");
    chk("tmo_err_sticky", {31'h0, dma_error}, 32'h1);

    // Dropped request during GRANT
    start(16'h0500);
    tick();
    BR = 1'b1;
    tick();
    dev_req = 1'b1; dev_addr = 16'h0200;
    tick();
    dev_req = 1'b0;
    chk("drop_flag", {31'h0, req_dropped}, 32'h1);
    tick();
    chk("drop_bg", {31'h0, BG}, 32'h1);
    finish_xfer("drop");

    // DMA withdraws BR while quiescing
    start(16'h0580);
    tick();
    BR = 1'b1; cpu_mem_busy = 1'b1;
    tick();
    chk("wd_stall", {31'h0, cpu_bus_stall}, 32'h1);
    BR = 1'b0;
    tick();
    cpu_mem_busy = 1'b0;
    chk("wd_stall_off", {31'h0, cpu_bus_stall}, 32'h0);
    tick(); tick();
    chk("wd_bg", {31'h0, BG}, 32'h0);

    // Reset mid-grant
    start(16'h0600);
    tick();
    BR = 1'b1;
    tick();
    chk("rmg_bg_high", {31'h0, BG}, 32'h1);
    reset_n = 1'b0;
    tick();
    chk("rmg_bg", {31'h0, BG}, 32'h0);
    chk("rmg_stall", {31'h0, cpu_bus_stall}, 32'h0);
    chk("rmg_cmd", {16'h0, cmd}, {16'h0, zz});
    chk("rmg_err", {31'h0, dma_error}, 32'h0);
    BR = 1'b0;
    dev_req = 1'b1; dev_addr = 16'h0777;
    tick();
    dev_req = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rmg_drop", {31'h0, req_dropped}, 32'h0);
    start(16'h0010);
    tick();
    BR = 1'b1;
    tick();
    finish_xfer("rmg");

    // Early interrupt, same cycle as BR falling
    start(16'h0700);
    tick();
    BR = 1'b1;
    tick();
    tick();
    BR = 1'b0; interrupt = 1'b1;
    done_q.push_back(1);
    tick();
    interrupt = 1'b0;
    chk("early_bg", {31'h0, BG}, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("early_done_drained", done_q.size(), 32'h0);
    chk("early_stall", {31'h0, cpu_bus_stall}, 32'h0);
    start(16'h0720);
    tick();
    chk("early_idle_again", {31'h0, BG}, 32'h0);

    chk("cmd_q_drained", cmd_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- CPU-side counterpart of the DMA write engine; owns the BR/BG handshake and the one-cycle DMA command.
- On a device "data ready" pulse it issues the target memory address on cmd and waits for BR.
- It grants the bus with BG once the CPU has no memory access in flight, then stalls CPU memory use while BG is high.
- It releases the bus when BR falls and pulses dma_done to the CPU after the DMA's end-of-transfer interrupt.

Parameters:
- WORD_SIZE, 16, width of addresses and cmd.
- BR_TIMEOUT, 64, cycles to wait for BR after a command before aborting.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- dev_req  input  1  one-cycle pulse from external device: transfer ready.
- dev_addr  input  WORD_SIZE  destination base address, sampled with dev_req.
- cpu_mem_busy  input  1  CPU has an instruction/data memory access in flight.
- BR  input  1  bus request from DMA.
- interrupt  input  1  DMA end-of-transfer pulse.
- BG  output  1  bus grant to DMA.
- cmd  output  WORD_SIZE  DMA command; high-impedance except in CMD state.
- cpu_bus_stall  output  1  CPU must not start memory accesses.
- dma_done  output  1  one-cycle completion pulse to CPU.
- dma_error  output  1  sticky: BR timeout occurred.
- req_dropped  output  1  sticky: dev_req arrived while not IDLE.

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE, BG=0, cmd=all-z, cpu_bus_stall=0, dma_done=0, dma_error=0, req_dropped=0, timeout counter=0. Reset takes effect from any state, including mid-grant; BG drops at that edge.
- IDLE
  - dev_req=1: latch dev_addr and go to CMD.
  - All other inputs are ignored.
- CMD (exactly 1 cycle)
  - cmd=latched address.
  - Next state is WAIT_BR; timeout counter cleared.
- WAIT_BR
  - cmd=z.
  - Counter increments each cycle.
  - BR=1 and cpu_mem_busy=0: go to GRANT.
  - BR=1 and cpu_mem_busy=1: go to QUIESCE.
  - Counter reaches BR_TIMEOUT-1 with BR still 0: set dma_error and return to IDLE.
- QUIESCE
  - cpu_bus_stall=1, so no new CPU accesses start.
  - Go to GRANT on the first cycle with cpu_mem_busy=0.
- GRANT
  - BG=1 and cpu_bus_stall=1, registered. BG rises the cycle after the transition decision, i.e. 1 cycle after BR is seen with the bus quiet.
  - BR=0: go to RELEASE.
- RELEASE
  - BG=0; cpu_bus_stall stays 1.
  - Go to WAIT_IRQ.
- WAIT_IRQ
  - cpu_bus_stall=0.
  - interrupt=1: dma_done=1 for exactly one cycle, then IDLE.
  - Also accept an interrupt arriving during RELEASE: record it and pulse dma_done on entry to WAIT_IRQ, then go to IDLE.
- BG is never 1 outside GRANT. cpu_bus_stall=1 exactly in QUIESCE, GRANT and RELEASE.
- dev_req in any non-IDLE state: ignored and req_dropped set. The latched address is not changed.
- dev_req and reset_n=0 in the same cycle: reset wins.
- BR dropping in QUIESCE (DMA withdrew): return to IDLE with no grant and no dma_done.
- interrupt outside RELEASE and WAIT_IRQ: ignored.
- Timeout counter is WORD_SIZE bits wide and saturates; it never wraps.

Test Plan:
- Nominal transfer:
  - Stimulus: dev_req with dev_addr=16'h01F4; BR=1 two cycles after cmd; cpu_mem_busy=0; BR held 13 cycles; interrupt 1 cycle after BR falls.
  - Required: cmd=16'h01F4 for exactly 1 cycle, otherwise z. BG rises 1 cycle after BR and falls 1 cycle after BR=0. dma_done pulses once.
- Busy CPU:
  - Stimulus: cpu_mem_busy=1 for 3 cycles after BR rises.
  - Required: cpu_bus_stall=1 immediately. BG stays 0 until the cycle after cpu_mem_busy falls.
- Timeout:
  - Stimulus: command issued; BR never asserted.
  - Required: dma_error=1 after 64 cycles in WAIT_BR; return to IDLE; BG never 1. A following dev_req is accepted normally.
- Dropped request:
  - Stimulus: second dev_req with dev_addr=16'h0200 during GRANT.
  - Required: req_dropped=1; no second cmd issued; transfer completes unaffected.
- Reset mid-grant:
  - Stimulus: reset_n=0 while BG=1.
  - Required: BG=0, cpu_bus_stall=0, cmd=z at that edge. After reset release, dev_req with 16'h0010 gives cmd=16'h0010.
- Early interrupt:
  - Stimulus: interrupt asserted in the same cycle BR falls.
  - Required: dma_done pulses exactly once; arbiter returns to IDLE.
